// File: rtl/bus_timer_dev.sv
// bus_timer_dev: data-bus responder providing a prescaled 64-bit mtime counter,
// a 64-bit mtimecmp register and a registered level timer interrupt.
`default_nettype none

module bus_timer_dev #(
  parameter logic [31:0] PrescaleReset = 32'd0,
  parameter logic [63:0] CmpReset      = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_timer_o
);

  localparam logic [2:0] IdxMtimeLo = 3'd0;
  localparam logic [2:0] IdxMtimeHi = 3'd1;
  localparam logic [2:0] IdxCmpLo   = 3'd2;
  localparam logic [2:0] IdxCmpHi   = 3'd3;
  localparam logic [2:0] IdxPresc   = 3'd4;
  localparam logic [2:0] IdxCtrl    = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        en_q, en_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic [2:0]  idx;
  logic        mapped;
  logic        wr;
  logic        rd;
  logic        be_any;
  logic        tick;
  logic        unused_addr;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign idx         = addr_i[4:2];
  assign mapped      = (idx <= IdxCtrl);
  assign wr          = req_i && mapped && we_i;
  assign rd          = req_i && mapped && !we_i;
  assign be_any      = |be_i;
  assign tick        = en_q && (cnt_q == prescale_q);
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    rvalid_d   = req_i;
    err_d      = req_i && !mapped;
    rdata_d    = 32'd0;
    irq_d      = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (rd) begin
      unique case (idx)
        IdxMtimeLo: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        IdxMtimeHi: rdata_d = shadow_q;
        IdxCmpLo:   rdata_d = mtimecmp_q[31:0];
        IdxCmpHi:   rdata_d = mtimecmp_q[63:32];
        IdxPresc:   rdata_d = prescale_q;
        IdxCtrl:    rdata_d = {31'd0, en_q};
        default:    rdata_d = 32'd0;
      endcase
    end

    // An mtime write replaces the tick for that cycle; the other half keeps its value (no carry).
    if (wr && be_any) begin
      unique case (idx)
        IdxMtimeLo: mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata_i, be_i)};
        IdxMtimeHi: mtime_d = {merge_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        IdxCmpLo:   mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], wdata_i, be_i);
        IdxCmpHi:   mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wdata_i, be_i);
        IdxPresc: begin
          prescale_d = merge_be(prescale_q, wdata_i, be_i);
          cnt_d      = 32'd0;
        end
        IdxCtrl: begin
          if (be_i[0]) en_d = wdata_i[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CmpReset;
      prescale_q <= PrescaleReset;
      cnt_q      <= 32'd0;
      shadow_q   <= 32'd0;
      en_q       <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign irq_timer_o = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_timer_dev.sv
// Randomized scoreboard bench for bus_timer_dev against a register-level reference model.
`default_nettype none

module tb_bus_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, irq_timer_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  bus_timer_dev dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .irq_timer_o (irq_timer_o)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_on = 1'b0;

  // Reference model state: values the DUT registers hold after the most recent edge.
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_pre, m_cnt, m_shadow;
  logic        m_en, exp_irq;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_time = 64'd0; m_cmp = '1; m_pre = 32'd0; m_cnt = 32'd0;
    m_shadow = 32'd0; m_en = 1'b0; exp_irq = 1'b0;
    q.delete();
  endtask

  // One bus cycle: drive at negedge, predict response and next state, then pass the posedge.
  task automatic step(input bit req, input bit we, input logic [2:0] idx,
                      input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] a, ncnt;
    logic [63:0] nt;
    exp_t        e;
    bit          ok, tick;
    @(negedge clk);
    a = $urandom; a[4:2] = idx; a[1:0] = 2'b00;
    req_i = req; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    #1 check("gnt", gnt_o, req);
    exp_irq = (m_time >= m_cmp);
    ok = req && (idx < 3'd6);
    if (req) begin
      e.err = !ok;
      e.rdata = 32'd0;
      if (ok && !we) begin
        case (idx)
          3'd0: e.rdata = m_time[31:0];
          3'd1: e.rdata = m_shadow;
          3'd2: e.rdata = m_cmp[31:0];
          3'd3: e.rdata = m_cmp[63:32];
          3'd4: e.rdata = m_pre;
          default: e.rdata = {31'd0, m_en};
        endcase
      end
      q.push_back(e);
    end
    tick = m_en && (m_cnt == m_pre);
    ncnt = !m_en ? m_cnt : (tick ? 32'd0 : m_cnt + 32'd1);
    nt   = tick ? m_time + 64'd1 : m_time;
    if (ok && !we && idx == 3'd0) m_shadow = m_time[63:32];
    if (ok && we && be != 4'd0) begin
      case (idx)
        3'd0: nt = {m_time[63:32], merge(m_time[31:0], wd, be)};
        3'd1: nt = {merge(m_time[63:32], wd, be), m_time[31:0]};
        3'd2: m_cmp[31:0] = merge(m_cmp[31:0], wd, be);
        3'd3: m_cmp[63:32] = merge(m_cmp[63:32], wd, be);
        3'd4: begin m_pre = merge(m_pre, wd, be); ncnt = 32'd0; end
        default: if (be[0]) m_en = wd[0];
      endcase
    end
    m_time = nt;
    m_cnt  = ncnt;
    @(posedge clk);
  endtask

  task automatic rd(input logic [2:0] idx);
    step(1'b1, 1'b0, idx, 32'd0, 4'd0);
  endtask
  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    step(1'b1, 1'b1, idx, d, 4'hF);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  // Monitor: every response must appear exactly one cycle after its grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        check("rvalid", rvalid_o, q.size() > 0);
        if (rvalid_o && q.size() > 0) begin
          e = q.pop_front();
          check("rdata", rdata_o, e.rdata);
          check("err", err_o, e.err);
        end else if (!rvalid_o) begin
          check("rdata_idle", rdata_o, 32'd0);
          check("err_idle", err_o, 1'b0);
        end
        check("irq", irq_timer_o, exp_irq);
      end
    end
  end

  initial begin
    logic [2:0]  ridx;
    logic [31:0] rwd;
    logic [3:0]  rbe;
    int unsigned rsel;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", err_o, 1'b0);
    check("rst_irq", irq_timer_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 6; i++) rd(3'(i));

    wr(3'd4, 32'd3); wr(3'd5, 32'd1);
    idle(40);
    rd(3'd0); rd(3'd1);

    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'd0); wr(3'd4, 32'd0); wr(3'd5, 32'd1);
    rd(3'd0); rd(3'd1);

    wr(3'd5, 32'd0); wr(3'd0, 32'd0); wr(3'd1, 32'd0);
    wr(3'd3, 32'd0); wr(3'd2, 32'd5); wr(3'd5, 32'd1);
    idle(10);
    wr(3'd3, 32'd1);
    idle(3);

    wr(3'd6, 32'h1234_5678); rd(3'd7);
    for (int i = 0; i < 6; i++) rd(3'(i));

    wr(3'd5, 32'd0);
    step(1'b1, 1'b1, 3'd5, 32'd1, 4'b0010);
    rd(3'd5);
    rd(3'd2); wr(3'd2, 32'hA5A5_0007); rd(3'd2);
    step(1'b1, 1'b1, 3'd4, 32'd9, 4'd0);
    rd(3'd4);

    for (int i = 0; i < 1500; i++) begin
      rsel = $urandom_range(0, 9);
      ridx = 3'($urandom_range(0, 7));
      rwd  = $urandom;
      rbe  = 4'($urandom);
      if (ridx == 3'd4) rwd = $urandom_range(0, 3);
      if (ridx == 3'd1 || ridx == 3'd3) rwd = $urandom_range(0, 2);
      step(rsel < 7, $urandom_range(0, 1) == 1, ridx, rwd, rbe);
    end
    idle(2);

    // Reset while a response is on the bus: it must vanish and never reappear.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'd0;
    mon_on = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_rvalid", rvalid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid_o, 1'b0);
    check("mid_rst_rdata", rdata_o, 32'd0);
    req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;
    for (int i = 0; i < 6; i++) rd(3'(i));
    idle(3);
    check("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
